// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents: loader FSM state enum, IM write-strobe constants, the default
// IM depth with the address width derived from it, and the checksum helper.
package boot_pkg;

    localparam int IM_DEPTH_DEF = 16384;
    localparam int BOOT_AW      = $clog2(IM_DEPTH_DEF);

    // IM byte write strobes are active-low.
    localparam logic [3:0] WEB_ALL  = 4'h0;
    localparam logic [3:0] WEB_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } boot_state_e;

    // Running checksum: plain 32-bit add, wrapping mod 2^32.
    function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/im_boot_loader_if.sv
// Byte-stream handshake carrying the boot image into the loader.
// Signals: rx_data (byte), rx_valid (byte available), rx_ready (byte accepted).
// Modports: master = stream source (UART RX / bench), slave = loader.
interface im_boot_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/byte_packer.sv
// Little-endian 8->32 assembler. Byte k of each group of four lands in
// bits [8k+7:8k]; wvalid_o pulses for one cycle after the 4th byte.
// Ports: clk, rst (async active-low), accept_i (byte transfers this edge),
//        clear_i (drop partial word), byte_i, word_o, wvalid_o.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        wvalid_o
);

    logic [1:0]  idx_q,    idx_d;
    logic [31:0] word_q,   word_d;
    logic        wvalid_q, wvalid_d;

    // Next lane index, word contents and completion pulse.
    always_comb begin
        idx_d    = idx_q;
        word_d   = word_q;
        wvalid_d = 1'b0;
        if (clear_i) begin
            idx_d  = 2'd0;
            word_d = 32'h0000_0000;
        end else if (accept_i) begin
            case (idx_q)
                2'd0:    word_d[7:0]   = byte_i;
                2'd1:    word_d[15:8]  = byte_i;
                2'd2:    word_d[23:16] = byte_i;
                2'd3:    word_d[31:24] = byte_i;
                default: word_d        = word_q;
            endcase
            idx_d    = idx_q + 2'd1;
            wvalid_d = (idx_q == 2'd3);
        end else begin
            idx_d = idx_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= 2'd0;
            word_q   <= 32'h0000_0000;
            wvalid_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign word_o   = word_q;
    assign wvalid_o = wvalid_q;

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader in front of the CPU instruction memory. Receives a frame
// LEN, N data words, CSUM as a little-endian byte stream, writes the data
// words to IM from address 0, verifies the checksum and then releases the CPU.
// Ports: clk, rst (async active-low), rx (byte stream, slave side), reload
//        (restart from DONE), cpu_IM_A (CPU fetch address), IM_A/IM_DI/IM_WEB
//        (IM port), cpu_hold, boot_done, boot_err (sticky), word_cnt.
module im_boot_loader
    import boot_pkg::*;
#(
    parameter  int IM_DEPTH   = IM_DEPTH_DEF,
    parameter  int DATA_WIDTH = 32,
    localparam int AW         = $clog2(IM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    im_boot_loader_if.slave       rx,
    input  logic                  reload,
    input  logic [AW-1:0]         cpu_IM_A,
    output logic [AW-1:0]         IM_A,
    output logic [DATA_WIDTH-1:0] IM_DI,
    output logic [3:0]            IM_WEB,
    output logic                  cpu_hold,
    output logic                  boot_done,
    output logic                  boot_err,
    output logic [AW:0]           word_cnt
);

    localparam logic [31:0] DEPTH_W = 32'(IM_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    boot_state_e state_q, state_d;
    logic [AW:0] len_q,   len_d;
    logic [AW:0] cnt_q,   cnt_d;
    logic [31:0] sum_q,   sum_d;
    logic [31:0] di_q,    di_d;
    logic [3:0]  web_q,   web_d;
    logic        hold_q,  hold_d;
    logic        done_q,  done_d;
    logic        err_q,   err_d;
    logic        rdy_q,   rdy_d;

    logic        accept_s;
    logic        clear_s;
    logic        wvalid_s;
    logic [31:0] word_s;
    logic        writing_s;

    assign accept_s  = rx.rx_valid & rdy_q;
    assign clear_s   = (state_q == S_DONE) & reload;
    // The write strobe register doubles as the "write happening now" flag.
    assign writing_s = (web_q == WEB_ALL);

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept_s),
        .clear_i  (clear_s),
        .byte_i   (rx.rx_data),
        .word_o   (word_s),
        .wvalid_o (wvalid_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (!wvalid_s)              state_d = S_LEN;
                else if (word_s > DEPTH_W)  state_d = S_ERR;
                else if (word_s == 32'd0)   state_d = S_CSUM;
                else                        state_d = S_DATA;
            end
            S_DATA: begin
                // Leave once the N-th write is on the IM port.
                if (writing_s && ((cnt_q + CNT_ONE) == len_q)) state_d = S_CSUM;
                else                                           state_d = S_DATA;
            end
            S_CSUM: begin
                if (!wvalid_s)            state_d = S_CSUM;
                else if (word_s == sum_q) state_d = S_DONE;
                else                      state_d = S_ERR;
            end
            S_DONE: begin
                if (reload) state_d = S_LEN;
                else        state_d = S_DONE;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // FSM outputs, computed one cycle ahead so they leave registered.
    always_comb begin
        rdy_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        // The CPU is released only from the second cycle in DONE onwards.
        hold_d = !((state_q == S_DONE) && (state_d == S_DONE));
        if ((state_q == S_DATA) && wvalid_s) begin
            web_d = WEB_ALL;
            di_d  = word_s;
        end else begin
            web_d = WEB_NONE;
            di_d  = di_q;
        end
    end

    // Frame length, write counter and checksum accumulator.
    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (clear_s) begin
            len_d = '0;
            cnt_d = '0;
            sum_d = 32'h0000_0000;
        end else begin
            if ((state_q == S_LEN) && wvalid_s) len_d = word_s[AW:0];
            else                                len_d = len_q;
            // The word is summed as it is written, so LEN and CSUM never enter.
            if (writing_s) begin
                cnt_d = cnt_q + CNT_ONE;
                sum_d = csum_add(sum_q, di_q);
            end else begin
                cnt_d = cnt_q;
                sum_d = sum_q;
            end
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            hold_q <= 1'b1;
            web_q  <= WEB_NONE;
            di_q   <= 32'h0000_0000;
            len_q  <= '0;
            cnt_q  <= '0;
            sum_q  <= 32'h0000_0000;
        end else begin
            rdy_q  <= rdy_d;
            done_q <= done_d;
            err_q  <= err_d;
            hold_q <= hold_d;
            web_q  <= web_d;
            di_q   <= di_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
        end
    end

    // Loader owns the IM address everywhere except DONE.
    assign IM_A        = (state_q == S_DONE) ? cpu_IM_A : cnt_q[AW-1:0];
    assign IM_DI       = di_q;
    assign IM_WEB      = web_q;
    assign rx.rx_ready = rdy_q;
    assign cpu_hold    = hold_q;
    assign boot_done   = done_q;
    assign boot_err    = err_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader (small IM so the full-fill and
// oversize-LEN boundaries stay cheap). The stimulus process sends frames and
// records what the frame must produce; a single compare process checks the
// IM port and status outputs every cycle and performs end-of-frame checks.
module tb_im_boot_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    im_boot_loader_if rx_if ();

    logic          reload   = 1'b0;
    logic [AW-1:0] cpu_IM_A = '0;
    logic [AW-1:0] IM_A;
    logic [31:0]   IM_DI;
    logic [3:0]    IM_WEB;
    logic          cpu_hold;
    logic          boot_done;
    logic          boot_err;
    logic [AW:0]   word_cnt;

    im_boot_loader #(.IM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if.slave),
        .reload    (reload),
        .cpu_IM_A  (cpu_IM_A),
        .IM_A      (IM_A),
        .IM_DI     (IM_DI),
        .IM_WEB    (IM_WEB),
        .cpu_hold  (cpu_hold),
        .boot_done (boot_done),
        .boot_err  (boot_err),
        .word_cnt  (word_cnt)
    );

    // Written only by the stimulus process: the model's expectations.
    int          frame_seq = 0;
    int          chk_seq   = 0;
    int          exp_n     = 0;
    int          exp_wcnt  = 0;
    logic        exp_done  = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_data [0:31];
    logic [31:0] frame_w  [0:31];
    int          lit_n     = 0;
    string       lit_name [0:7];
    logic [31:0] lit_act  [0:7];
    logic [31:0] lit_exp  [0:7];

    // Written only by the compare process.
    int          n_cmp = 0;
    int          n_bad = 0;
    int          seen_frame = 0;
    int          seen_chk   = 0;
    int          wr_idx     = 0;
    logic        prev_done  = 1'b0;
    logic [31:0] mem_seen [0:DEPTH-1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compare process.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_seq != seen_frame) begin
                seen_frame = frame_seq;
                wr_idx     = 0;
            end
            if (IM_WEB == 4'h0) begin
                check("write_expected", 32'(wr_idx < exp_n), 32'd1);
                if (wr_idx < exp_n) begin
                    check("write_addr", 32'(IM_A), 32'(wr_idx));
                    check("write_data", IM_DI, exp_data[wr_idx]);
                end
                mem_seen[IM_A] = IM_DI;
                wr_idx++;
            end else begin
                check("web_idle", 32'(IM_WEB), 32'h0000000F);
            end
            check("done_err_exclusive", 32'(boot_done & boot_err), 32'd0);
            if (boot_done) begin
                check("im_a_from_cpu", 32'(IM_A), 32'(cpu_IM_A));
                check("hold_in_done", 32'(cpu_hold), prev_done ? 32'd0 : 32'd1);
                check("ready_in_done", 32'(rx_if.rx_ready), 32'd0);
            end else begin
                check("hold_busy", 32'(cpu_hold), 32'd1);
                check("im_a_from_loader", 32'(IM_A), 32'(word_cnt[AW-1:0]));
                check("ready_busy", 32'(rx_if.rx_ready), boot_err ? 32'd0 : 32'd1);
            end
            prev_done = boot_done;
            if (chk_seq != seen_chk) begin
                seen_chk = chk_seq;
                check("final_done", 32'(boot_done), 32'(exp_done));
                check("final_err", 32'(boot_err), 32'(exp_err));
                check("final_word_cnt", 32'(word_cnt), 32'(exp_wcnt));
                check("final_write_count", 32'(wr_idx), 32'(exp_n));
                check("final_hold", 32'(cpu_hold), exp_done ? 32'd0 : 32'd1);
                for (int i = 0; i < lit_n; i++) check(lit_name[i], lit_act[i], lit_exp[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget = 0;
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        while (!rx_if.rx_ready && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gaps && ($urandom_range(1, 0) == 1)) repeat ($urandom_range(5, 1)) tick();
        end
    endtask

    // Checksum of the first n frame words, wrapping at 32 bits.
    function automatic logic [31:0] model_sum(input int n);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < n; i++) s = s + frame_w[i];
        return s;
    endfunction

    task automatic wait_end();
        int budget;
        budget = 0;
        while (!(boot_done | boot_err) && budget < 400) begin
            tick();
            budget++;
        end
        repeat (3) tick();
    endtask

    task automatic add_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_name[lit_n] = nm;
        lit_act[lit_n]  = act;
        lit_exp[lit_n]  = exp;
        lit_n++;
    endtask

    task automatic request_final();
        chk_seq++;
        tick();
        tick();
        lit_n = 0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic set_idle_expect(input int n_writes);
        exp_n    = n_writes;
        exp_wcnt = 0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Model of a whole frame: writes, final counter and pass/fail verdict.
    task automatic run_frame(input int len, input logic [31:0] csum, input bit gaps);
        logic [31:0] s;
        for (int i = 0; i < 32; i++) exp_data[i] = frame_w[i];
        exp_n    = (len <= DEPTH) ? len : 0;
        s        = model_sum(exp_n);
        exp_done = (len <= DEPTH) && (s == csum);
        exp_err  = !exp_done;
        exp_wcnt = exp_n;
        frame_seq++;
        send_word(32'(len), gaps);
        if (len <= DEPTH) begin
            for (int i = 0; i < len; i++) send_word(frame_w[i], gaps);
            send_word(csum, gaps);
        end
        wait_end();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Stimulus process.
    initial begin
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        #1 rst = 1'b0;
        repeat (3) tick();
        set_idle_expect(0);
        frame_seq++;
        request_final();
        rst = 1'b1;
        tick();

        // Three-word program, back-to-back bytes.
        frame_w[0] = 32'h0000_0013;
        frame_w[1] = 32'h0010_0093;
        frame_w[2] = 32'hDEAD_BEEF;
        run_frame(3, 32'hDEBD_BF95, 1'b0);
        add_lit("model_sum3", model_sum(3), 32'hDEBD_BF95);
        add_lit("im0", mem_seen[0], 32'h0000_0013);
        add_lit("im1", mem_seen[1], 32'h0010_0093);
        add_lit("im2", mem_seen[2], 32'hDEAD_BEEF);
        request_final();
        for (int i = 0; i < 5; i++) begin
            cpu_IM_A = AW'(i * 5 + 3);
            tick();
        end

        // Same frame with idle gaps.
        pulse_reload();
        cpu_IM_A = 4'hA;
        run_frame(3, 32'hDEBD_BF95, 1'b1);
        request_final();

        // Empty frame.
        pulse_reload();
        run_frame(0, 32'h0, 1'b0);
        request_final();

        // Bad checksum; reload in ERR must be ignored.
        pulse_reload();
        frame_w[0] = 32'h1;
        frame_w[1] = 32'h2;
        run_frame(2, 32'h4, 1'b0);
        add_lit("model_sum2", model_sum(2), 32'h3);
        request_final();
        pulse_reload();
        repeat (3) tick();
        request_final();

        // Oversize LEN: error right after the word completes, no writes.
        do_reset();
        set_idle_expect(0);
        exp_err = 1'b1;
        frame_seq++;
        send_word(32'(DEPTH + 1), 1'b0);
        add_lit("err_not_yet", 32'(boot_err), 32'd0);
        tick();
        add_lit("err_after_len", 32'(boot_err), 32'd1);
        repeat (4) tick();
        request_final();

        // Full fill: N equals the IM depth.
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_w[i] = 32'h0101_0101 * (i + 1) + 32'h7000_0000;
        run_frame(DEPTH, model_sum(DEPTH), 1'b0);
        request_final();

        // Reset mid-load after 5 data bytes (one word already written).
        do_reset();
        frame_w[0] = 32'h1122_3344;
        for (int i = 0; i < 32; i++) exp_data[i] = frame_w[i];
        set_idle_expect(1);
        frame_seq++;
        send_word(32'd3, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55);
        tick();
        tick();
        rst = 1'b0;
        tick();
        request_final();
        rst = 1'b1;
        tick();

        frame_w[0] = 32'hAABB_CCDD;
        run_frame(1, 32'hAABB_CCDD, 1'b0);
        add_lit("im0_after_reset", mem_seen[0], 32'hAABB_CCDD);
        request_final();
        pulse_reload();
        run_frame(1, 32'hAABB_CCDD, 1'b1);
        request_final();

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
